// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter, the two cache miss paths and the external memory port.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_arbiter_if #(
   parameter int unsigned BEAT_W = 2
);
   logic              ic_req;
   logic [31:0]       ic_addr;
   logic              dc_req;
   logic              dc_we;
   logic [31:0]       dc_addr;
   logic [31:0]       dc_wdata;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_rnw;
   logic [31:0]       mem_req_addr;
   logic [31:0]       mem_req_wdata;
   logic              mem_rdata_valid;
   logic [31:0]       mem_rdata;
   logic              fill_valid;
   logic              fill_dcache;
   logic [BEAT_W-1:0] fill_beat;
   logic [31:0]       fill_data;
   logic              ic_done;
   logic              dc_done;
   logic              Stall;

   modport master (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
      input  mem_req_ready, mem_rdata_valid, mem_rdata,
      output mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata,
      output fill_valid, fill_dcache, fill_beat, fill_data, ic_done, dc_done, Stall
   );

   modport slave (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
      output mem_req_ready, mem_rdata_valid, mem_rdata,
      input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata,
      input  fill_valid, fill_dcache, fill_beat, fill_data, ic_done, dc_done, Stall
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between icache line fills and dcache
// fills/write-through stores; the data side has fixed priority. Drives pipeline Stall.
module mem_arbiter #(
   parameter int unsigned LINE_BEATS = 4,
   parameter int unsigned BEAT_W     = 2
) (
   input  logic          CLK,
   input  logic          reset,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StFill, StDone} state_e;

   localparam logic [31:0]       LineMask = ~(LINE_BEATS * 32'd4 - 32'd1);
   localparam logic [31:0]       WordMask = 32'hFFFF_FFFC;
   localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_BEATS - 1);

   state_e            state_q, state_d;
   logic              grant_q, grant_d;  // 1 = dcache owns the port
   logic              rnw_q, rnw_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic              fill_valid_q, fill_valid_d;
   logic [BEAT_W-1:0] fill_beat_q, fill_beat_d;
   logic [31:0]       fill_data_q, fill_data_d;
   logic              ic_done_q, ic_done_d;
   logic              dc_done_q, dc_done_d;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rnw_d        = rnw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      fill_valid_d = 1'b0;
      fill_beat_d  = fill_beat_q;
      fill_data_d  = fill_data_q;
      ic_done_d    = 1'b0;
      dc_done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.dc_req) begin
               state_d = StIssue;
               grant_d = 1'b1;
               rnw_d   = ~bus.dc_we;
               addr_d  = bus.dc_addr & (bus.dc_we ? WordMask : LineMask);
               wdata_d = bus.dc_we ? bus.dc_wdata : 32'h0;
            end else if (bus.ic_req) begin
               state_d = StIssue;
               grant_d = 1'b0;
               rnw_d   = 1'b1;
               addr_d  = bus.ic_addr & LineMask;
               wdata_d = 32'h0;
            end
         end
         StIssue: begin
            if (bus.mem_req_ready) begin
               if (rnw_q) begin
                  state_d = StFill;
                  cnt_d   = '0;
               end else begin
                  // Writes pulse done on entry to StDone.
                  state_d   = StDone;
                  dc_done_d = grant_q;
                  ic_done_d = ~grant_q;
               end
            end
         end
         StFill: begin
            if (bus.mem_rdata_valid) begin
               fill_valid_d = 1'b1;
               fill_beat_d  = cnt_q;
               fill_data_d  = bus.mem_rdata;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == LastBeat) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            // Reads spend one extra cycle here so done follows the last fill beat.
            if (ic_done_q || dc_done_q) begin
               state_d = StIdle;
            end else begin
               dc_done_d = grant_q;
               ic_done_d = ~grant_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         rnw_q        <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         cnt_q        <= '0;
         fill_valid_q <= 1'b0;
         fill_beat_q  <= '0;
         fill_data_q  <= 32'h0;
         ic_done_q    <= 1'b0;
         dc_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rnw_q        <= rnw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         fill_valid_q <= fill_valid_d;
         fill_beat_q  <= fill_beat_d;
         fill_data_q  <= fill_data_d;
         ic_done_q    <= ic_done_d;
         dc_done_q    <= dc_done_d;
      end
   end

   assign bus.mem_req_valid = (state_q == StIssue);
   assign bus.mem_req_rnw   = rnw_q;
   assign bus.mem_req_addr  = addr_q;
   assign bus.mem_req_wdata = wdata_q;
   assign bus.fill_valid    = fill_valid_q;
   assign bus.fill_dcache   = grant_q;
   assign bus.fill_beat     = fill_beat_q;
   assign bus.fill_data     = fill_data_q;
   assign bus.ic_done       = ic_done_q;
   assign bus.dc_done       = dc_done_q;
   assign bus.Stall         = (bus.ic_req & ~ic_done_q) | (bus.dc_req & ~dc_done_q);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences all off-chip memory traffic for the 3-stage CPU. It owns the single external memory command/data port and shares it between the instruction-cache miss path and the data-cache path (read-miss line fills and write-through stores). It drives the pipeline `Stall` input consumed by the datapath and returns fill beats to the requesting cache. Fixed priority: data side wins, because its instruction is older than the one being fetched.

## Interface
Parameters:
- `LINE_BEATS`, 4: 32-bit beats per cache line; power of two, ≥2.
- `BEAT_W`, 2: width of the beat index; equals log2(LINE_BEATS).

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high as decided.
- `ic_req`  in  1  icache miss pending; held high until `ic_done`.
- `ic_addr`  in  32  miss byte address; stable while `ic_req` is high.
- `dc_req`  in  1  dcache operation pending; held high until `dc_done`.
- `dc_we`  in  1  1 = write-through store, 0 = read-miss fill; stable with `dc_req`.
- `dc_addr`  in  32  dcache byte address.
- `dc_wdata`  in  32  store data, already byte-lane shifted.
- `mem_req_valid`  out  1  command valid.
- `mem_req_ready`  in  1  memory accepts the command when high together with valid.
- `mem_req_rnw`  out  1  1 = line read, 0 = word write.
- `mem_req_addr`  out  32  command address.
- `mem_req_wdata`  out  32  write data.
- `mem_rdata_valid`  in  1  one read beat present.
- `mem_rdata`  in  32  read beat data.
- `fill_valid`  out  1  registered fill beat to a cache.
- `fill_dcache`  out  1  1 = the beat targets the dcache, 0 = the icache.
- `fill_beat`  out  BEAT_W  index of the beat within the line.
- `fill_data`  out  32  beat data.
- `ic_done`  out  1  one-cycle completion pulse for the icache.
- `dc_done`  out  1  one-cycle completion pulse for the dcache.
- `Stall`  out  1  pipeline freeze to the datapath.

## Operation
State machine:
- **IDLE**
  - `dc_req` → grant D, go to ISSUE.
  - Otherwise `ic_req` → grant I, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `mem_req_valid` is high.
  - On `mem_req_valid & mem_req_ready`:
    - read → FILL, beat counter cleared to 0.
    - write → DONE.
- **FILL**
  - Each `mem_rdata_valid` registers `mem_rdata` onto the fill outputs with the current counter value, then increments the counter.
  - The beat with counter == LINE_BEATS-1 → DONE; the counter wraps to 0.
- **DONE**
  - Pulses the granted requester's done for one cycle, then returns to IDLE.

Command fields are registered at grant and held constant through ISSUE:
- Reads: `mem_req_addr` = request address with bits [log2(LINE_BEATS)+1:0] cleared (line-aligned). `mem_req_rnw`=1.
- Writes: `mem_req_addr` = `dc_addr` with bits [1:0] cleared, `mem_req_wdata` = `dc_wdata`, `mem_req_rnw`=0.

Stall and input rules:
- `Stall` is combinational: (`ic_req` & ~`ic_done`) | (`dc_req` & ~`dc_done`). The pipeline advances in the done cycle.
- `fill_dcache` equals the registered grant.
- `mem_rdata_valid` outside FILL is ignored and produces no fill and no error.
- A requester dropping its req mid-operation does not abort. The operation completes and done still pulses.
- Grant is only re-evaluated in IDLE. Requests arriving during an operation wait.

## Timing
Reset values, asynchronous to `reset`, all outputs 0:
- State IDLE; `mem_req_valid`, `fill_valid`, `ic_done`, `dc_done` = 0.
- Counter 0; address, data and grant registers 0.
- `Stall` follows its inputs even while `reset` is high.

Latency and handshake:
- A request seen in IDLE at edge N gives `mem_req_valid` high from N+1.
- A write whose `mem_req_ready` is high at edge N+1 gives `dc_done` in cycle N+2. Minimum write = 3 cycles from request to done.
- A read beat sampled at edge M appears on `fill_*` in cycle M+1.
- The last beat goes to DONE; done pulses in the cycle after the last `fill_valid`.
- `mem_req_valid` never drops before acceptance. Command fields do not change while valid and not ready.
- Back-to-back: an IDLE cycle always separates done from the next ISSUE. The minimum gap is 1 cycle.

Conflicts and reset:
- `ic_req` and `dc_req` rising together: D is served first and I waits in IDLE arbitration. `Stall` stays high throughout, including the `dc_done` cycle, because `ic_req` is still pending.
- Reset asserted mid-FILL or mid-ISSUE: immediate return to IDLE with outputs at reset values. Stale beats arriving after deassertion are ignored (state is IDLE). Requesters reissue.

## Test plan
- Single icache miss, `ic_addr`=0x1000_0014, 4 beats 0xA0..0xA3 with 1-cycle gaps:
  - Command addr 0x1000_0010, `mem_req_rnw`=1.
  - `fill_beat` 0,1,2,3 with matching data and `fill_dcache`=0.
  - `ic_done` one cycle after the last beat; `Stall` low in the done cycle.
- dcache store, `dc_addr`=0x0000_2006, `dc_wdata`=0x0000_BEEF, `mem_req_ready` held low 3 cycles:
  - Command fields stable for 3 cycles; addr 0x0000_2004, wdata 0x0000_BEEF, rnw=0.
  - `dc_done` one cycle after acceptance.
- Simultaneous `ic_req`/`dc_req` (dcache read miss):
  - dcache line served first with `fill_dcache`=1.
  - `Stall` high through `dc_done`, then the icache line is issued after one IDLE cycle.
  - `ic_done` ends the stall.
- Spurious `mem_rdata_valid` while in IDLE and in ISSUE: no `fill_valid`, beat counter unchanged.
- `reset` pulsed after beat 1 of a fill:
  - All outputs are 0 immediately, asynchronously.
  - The remaining beats are ignored.
  - A reissued `ic_req` completes a full 4-beat line with beats starting at 0.
